uart_txrx: RTL and testbench
============================

Name: uart_txrx

Overview:
- Full-duplex 8N1 UART: an independent transmitter and receiver sharing one clock and one reset.
- Sits between a byte-wide local interface (valid-strobe handshake) and a single-wire serial line on each direction.
- Bit timing is a fixed integer divisor of the system clock, CLKS_PER_BIT. Example: 10 MHz / 115200 baud = 87.

Parameters:
CLKS_PER_BIT, 87, system clock cycles per serial bit; legal range 4..65535; counters sized to hold CLKS_PER_BIT-1.

Ports:
i_Clock  input  1  system clock; all logic is rising-edge.
soft_reset_n  input  1  asynchronous, active-low reset.
i_Rx_Serial  input  1  serial receive line; idles high; asynchronous to i_Clock.
o_Rx_DV  output  1  one-cycle pulse when a valid byte has been received.
o_Rx_Byte  output  8  last valid received byte; held until the next valid byte.
i_Tx_DV  input  1  one-cycle request to transmit i_Tx_Byte.
i_Tx_Byte  input  8  byte to transmit; sampled in the cycle i_Tx_DV is high.
o_Tx_Active  output  1  high while a frame is being transmitted.
o_Tx_Serial  output  1  serial transmit line; idles high.
o_Tx_Done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset (soft_reset_n low, asynchronous): both FSMs go to IDLE and all counters clear. Outputs: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Rx_DV=0, o_Rx_Byte=8'h00. Reset in mid-frame aborts that frame with no Done/DV pulse. Operation restarts cleanly after reset release.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- TX FSM: IDLE -> START -> DATA -> STOP -> CLEANUP -> IDLE.
  - IDLE: o_Tx_Serial=1. If i_Tx_DV=1, latch i_Tx_Byte, set o_Tx_Active=1, go to START.
  - START: drive 0 for CLKS_PER_BIT cycles.
  - DATA: drive bit index 0..7, each for CLKS_PER_BIT cycles.
  - STOP: drive 1 for CLKS_PER_BIT cycles. On the last cycle, o_Tx_Active goes to 0 and o_Tx_Done pulses high for exactly 1 cycle.
  - CLEANUP: 1 cycle, then IDLE.
  - Serial line changes exactly on bit boundaries. Frame length is 10*CLKS_PER_BIT cycles, starting the cycle after i_Tx_DV is sampled.
  - i_Tx_DV is ignored unless the FSM is in IDLE. A DV arriving during CLEANUP is dropped.
- RX input conditioning: i_Rx_Serial passes through a 2-flop synchronizer. All sampling uses the synchronized value, so there is a 2-cycle input latency.
- RX FSM: IDLE -> START -> DATA -> STOP -> CLEANUP -> IDLE.
  - IDLE: wait for synchronized line = 0.
  - START: count (CLKS_PER_BIT-1)/2 cycles to reach mid-bit. If the line is still 0, reset the counter and go to DATA. Otherwise treat it as a glitch and return to IDLE with no output change.
  - DATA: wait CLKS_PER_BIT cycles, sample into shift register bit index 0..7; repeat 8 times.
  - STOP: wait CLKS_PER_BIT cycles and sample.
    - If the sample is 1: load o_Rx_Byte from the shift register and pulse o_Rx_DV for 1 cycle.
    - If the sample is 0 (framing error): do not pulse o_Rx_DV and do not change o_Rx_Byte.
  - CLEANUP: 1 cycle, then IDLE. IDLE re-arms only on a falling level after the line has been seen high, so a stuck-low line produces no repeated frames.
- Timing tolerance: mid-bit sampling tolerates a start bit stretched by up to ~CLKS_PER_BIT/2 cycles. It also tolerates data bit periods that differ by ±2% from CLKS_PER_BIT.
- TX and RX are fully independent. Simultaneous TX and RX activity, including external loopback of o_Tx_Serial to i_Rx_Serial, must work without interaction.

Test Plan:
- TX 0xAB, CLKS_PER_BIT=87, i_Tx_DV pulsed 1 cycle -> o_Tx_Serial is 0,1,1,0,1,0,1,0,1,1 (start, LSB..MSB, stop), each level 87 cycles. o_Tx_Active is high for the frame. o_Tx_Done pulses once, 870 cycles after DV. The line then stays 1.
- RX 0x3F with a 96-cycle start bit, 86-cycle data bits and an 86-cycle stop bit -> exactly one o_Rx_DV pulse. o_Rx_Byte=8'h3F afterwards and holds.
- Loopback o_Tx_Serial->i_Rx_Serial, send 0x00, 0xFF, 0xA5 back-to-back (each i_Tx_DV issued on the prior o_Tx_Done) -> 3 DV pulses with matching bytes. An i_Tx_DV asserted mid-frame is ignored.
- RX glitch: line low for 20 cycles, then high -> no DV, o_Rx_Byte unchanged, FSM back in IDLE. A following valid 0x55 frame is received correctly.
- RX framing error: frame 0x12 with stop bit 0 -> no DV, o_Rx_Byte keeps its previous value. After the line returns high, the next frame 0x34 is received.
- Reset mid-frame: assert soft_reset_n low during TX bit 4 and RX bit 4 -> o_Tx_Serial=1, o_Tx_Active=0, o_Rx_Byte=0 immediately (asynchronous), with no Done/DV pulse. After release, a fresh 0x3F frame on each side completes normally.

Source files
------------

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing one clock.
// Bit timing is a fixed integer divisor of the system clock (CLKS_PER_BIT).
module uart_txrx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       soft_reset_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_CLEANUP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_CLEANUP} rx_state_t;

  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_idx;
  logic [7:0]       tx_data;

  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_idx;
  logic [7:0]       rx_shift;
  logic             rx_armed;
  logic             rx_p0;
  logic             rx_p1;

  // Transmit byte is captured only when a request is accepted in IDLE
  always_ff @(posedge i_Clock) begin
    if (tx_state == TX_IDLE && i_Tx_DV)
      tx_data <= i_Tx_Byte;
  end

  always_ff @(posedge i_Clock or negedge soft_reset_n) begin
    if (!soft_reset_n) begin
      tx_state    <= TX_IDLE;
      tx_cnt      <= '0;
      tx_idx      <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          o_Tx_Serial <= 1'b1;
          tx_cnt      <= '0;
          tx_idx      <= '0;
          if (i_Tx_DV) begin
            o_Tx_Serial <= 1'b0;
            o_Tx_Active <= 1'b1;
            tx_state    <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt != BIT_LAST) begin
            tx_cnt <= tx_cnt + 1'b1;
          end else begin
            tx_cnt      <= '0;
            o_Tx_Serial <= tx_data[0];
            tx_state    <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_cnt != BIT_LAST) begin
            tx_cnt <= tx_cnt + 1'b1;
          end else begin
            tx_cnt <= '0;
            if (tx_idx == 3'd7) begin
              o_Tx_Serial <= 1'b1;
              tx_state    <= TX_STOP;
            end else begin
              tx_idx      <= tx_idx + 3'd1;
              o_Tx_Serial <= tx_data[tx_idx + 3'd1];
            end
          end
        end
        TX_STOP: begin
          if (tx_cnt != BIT_LAST) begin
            tx_cnt <= tx_cnt + 1'b1;
          end else begin
            tx_cnt      <= '0;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b1;
            tx_state    <= TX_CLEANUP;
          end
        end
        TX_CLEANUP: tx_state <= TX_IDLE;
        default:    tx_state <= TX_IDLE;
      endcase
    end
  end

  // Two-flop synchronizer stage boundary for the asynchronous serial input
  always_ff @(posedge i_Clock or negedge soft_reset_n) begin
    if (!soft_reset_n) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= i_Rx_Serial;
      rx_p1 <= rx_p0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (rx_state == RX_DATA && rx_cnt == BIT_LAST)
      rx_shift[rx_idx] <= rx_p1;
  end

  // rx_armed blocks a new start until the line has been seen idle-high again
  always_ff @(posedge i_Clock or negedge soft_reset_n) begin
    if (!soft_reset_n) begin
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_armed  <= 1'b0;
      o_Rx_DV   <= 1'b0;
      o_Rx_Byte <= 8'h00;
    end else begin
      o_Rx_DV <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_idx <= '0;
          if (rx_armed && !rx_p1) begin
            rx_armed <= 1'b0;
            rx_state <= RX_START;
          end else if (rx_p1) begin
            rx_armed <= 1'b1;
          end
        end
        RX_START: begin
          if (rx_cnt != HALF_LAST) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt   <= '0;
            rx_state <= rx_p1 ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt != BIT_LAST) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt <= '0;
            rx_idx <= rx_idx + 3'd1;
            if (rx_idx == 3'd7)
              rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_cnt != BIT_LAST) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt <= '0;
            if (rx_p1) begin
              o_Rx_Byte <= rx_shift;
              o_Rx_DV   <= 1'b1;
            end
            rx_state <= RX_CLEANUP;
          end
        end
        RX_CLEANUP: rx_state <= RX_IDLE;
        default:    rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_txrx.sv
// Randomized bench for uart_txrx: a frame-level model predicts the TX line
// waveform and the list of bytes the receiver must deliver.
module tb_uart_txrx;
  localparam int CPB   = 87;
  localparam int FRAME = 10 * CPB;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       rx_drive = 1'b1;
  logic       loopback = 1'b0;
  logic       tx_dv    = 1'b0;
  logic [7:0] tx_byte  = 8'h00;
  logic       rx_line;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       tx_active;
  logic       tx_serial;
  logic       tx_done;

  assign rx_line = loopback ? tx_serial : rx_drive;

  uart_txrx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock      (clk),
    .soft_reset_n (rst_n),
    .i_Rx_Serial  (rx_line),
    .o_Rx_DV      (rx_dv),
    .o_Rx_Byte    (rx_byte),
    .i_Tx_DV      (tx_dv),
    .i_Tx_Byte    (tx_byte),
    .o_Tx_Active  (tx_active),
    .o_Tx_Serial  (tx_serial),
    .o_Tx_Done    (tx_done)
  );

  always #5 clk = ~clk;

  int         n_tests  = 0;
  int         n_fail   = 0;
  int         done_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_byte = 8'h00;

  always @(negedge clk) begin
    if (rx_dv === 1'b1) rx_q.push_back(rx_byte);
    if (tx_done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts at a negedge; DV is sampled at the next posedge (frame cycle t=0 follows).
  task automatic send_tx_check(input logic [7:0] b, input int inj_t);
    logic [9:0] frame;
    logic [9:0] sh;
    logic       exp_line;
    logic       exp_act;
    int         line_err = 0;
    int         act_err  = 0;
    int         done_at  = -1;
    int         done_n   = 0;
    frame   = {1'b1, b, 1'b0};
    tx_dv   = 1'b1;
    tx_byte = b;
    for (int t = 0; t <= FRAME + 1; t++) begin
      @(negedge clk);
      if (t == 0 || t == inj_t + 1) tx_dv = 1'b0;
      if (t == 0) tx_byte = ~b;
      if (t == inj_t) begin
        tx_dv   = 1'b1;
        tx_byte = ~b;
      end
      sh       = frame >> (t / CPB);
      exp_line = (t < FRAME) ? sh[0] : 1'b1;
      exp_act  = (t < FRAME);
      if (tx_serial !== exp_line) line_err++;
      if (tx_active !== exp_act) act_err++;
      if (tx_done === 1'b1) begin
        done_n++;
        if (done_at < 0) done_at = t;
      end
    end
    check($sformatf("tx_line_err_%02h", b), line_err, 0);
    check($sformatf("tx_active_err_%02h", b), act_err, 0);
    check($sformatf("tx_done_cycle_%02h", b), done_at, FRAME);
    check($sformatf("tx_done_pulses_%02h", b), done_n, 1);
  endtask

  task automatic send_rx(input logic [7:0] b, input int s_len, input int b_len,
                         input int p_len, input logic p_val);
    logic [7:0] sh;
    sh = b;
    rx_drive = 1'b0;
    repeat (s_len) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drive = sh[0];
      sh = sh >> 1;
      repeat (b_len) @(negedge clk);
    end
    rx_drive = p_val;
    repeat (p_len) @(negedge clk);
    rx_drive = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic expect_rx(input logic [7:0] b);
    exp_q.push_back(b);
    last_byte = b;
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
    check({tag, "_hold"}, 32'(rx_byte), 32'(last_byte));
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    logic [9:0] rxf;
    logic [9:0] sh;
    int         idle_err;
    int         done_before;

    repeat (3) @(negedge clk);
    check("rst_tx_serial", 32'(tx_serial), 1);
    check("rst_tx_active", 32'(tx_active), 0);
    check("rst_tx_done", 32'(tx_done), 0);
    check("rst_rx_dv", 32'(rx_dv), 0);
    check("rst_rx_byte", 32'(rx_byte), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // TX 0xAB; a request during the cleanup cycle must be dropped
    send_tx_check(8'hAB, FRAME);
    idle_err = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_active !== 1'b0) idle_err++;
    end
    check("tx_cleanup_dv_dropped", idle_err, 0);

    // RX 0x3F with stretched start bit and short data/stop bits
    send_rx(8'h3F, 96, 86, 86, 1'b1);
    expect_rx(8'h3F);
    check_rx("rx_3f");

    // Loopback, back-to-back frames, mid-frame request on the second
    loopback = 1'b1;
    send_tx_check(8'h00, -1); expect_rx(8'h00);
    send_tx_check(8'hFF, 300); expect_rx(8'hFF);
    send_tx_check(8'hA5, -1); expect_rx(8'hA5);
    repeat (10) @(negedge clk);
    check_rx("loop_fixed");
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      send_tx_check(b, int'($urandom_range(800, 10)));
      expect_rx(b);
    end
    repeat (10) @(negedge clk);
    check_rx("loop_rand");
    loopback = 1'b0;
    rx_drive = 1'b1;
    repeat (50) @(negedge clk);

    // Glitch shorter than half a bit, then a valid frame
    rx_drive = 1'b0;
    repeat (20) @(negedge clk);
    rx_drive = 1'b1;
    repeat (200) @(negedge clk);
    check_rx("glitch");
    send_rx(8'h55, CPB, CPB, CPB, 1'b1);
    expect_rx(8'h55);
    check_rx("after_glitch");

    // Framing error followed by a long stuck-low line, then a good frame
    send_rx(8'h12, CPB, CPB, CPB + 1000, 1'b0);
    check_rx("framing");
    send_rx(8'h34, CPB, CPB, CPB, 1'b1);
    expect_rx(8'h34);
    check_rx("after_framing");

    // Random bytes with timing jitter inside the tolerated window
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      send_rx(b, int'($urandom_range(110, 87)), int'($urandom_range(88, 86)),
              int'($urandom_range(88, 86)), 1'b1);
      expect_rx(b);
      check_rx($sformatf("rx_rand%0d", k));
    end

    // Reset in the middle of data bit 4 on both sides
    done_before = done_cnt;
    rxf     = {1'b1, 8'hC6, 1'b0};
    tx_dv   = 1'b1;
    tx_byte = 8'h5A;
    for (int t = 0; t <= 5 * CPB + 40; t++) begin
      @(negedge clk);
      if (t == 0) tx_dv = 1'b0;
      sh = rxf >> (t / CPB);
      rx_drive = sh[0];
    end
    #2 rst_n = 1'b0;
    #1;
    last_byte = 8'h00;
    check("midrst_tx_serial", 32'(tx_serial), 1);
    check("midrst_tx_active", 32'(tx_active), 0);
    check("midrst_tx_done", 32'(tx_done), 0);
    check("midrst_rx_dv", 32'(rx_dv), 0);
    check("midrst_rx_byte", 32'(rx_byte), 0);
    rx_drive = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("midrst_no_done", done_cnt, done_before);
    check_rx("midrst_no_dv");
    fork
      send_tx_check(8'h3F, -1);
      send_rx(8'h3F, CPB, CPB, CPB, 1'b1);
    join
    expect_rx(8'h3F);
    check_rx("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
